// File: rtl/rx_tx_pkg.sv
// Shared definitions for the port datapath: byte framing constants, the
// transmit sequencer state encoding and the CRC-32 next-state function.
package rx_tx_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE      = 8'hD5;

  localparam int PREAMBLE_LEN   = 7;
  localparam int MIN_DATA_BYTES = 60;
  localparam int MAX_DATA_BYTES = 1514;
  localparam int IFG_BYTES      = 12;

  localparam int BYTE_CNT_W = 11;

  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_SFD,
    TX_DATA,
    TX_PAD,
    TX_FCS,
    TX_IFG
  } tx_state_e;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // Reflected-register CRC-32; the data byte is consumed bit 7 first, which is
  // why the FCS bytes leave the framer bit-reversed.
  function automatic logic [31:0] crc32_next(input logic [DATA_WIDTH-1:0] data,
                                             input logic [31:0] crc);
    logic [31:0] c;
    c = crc;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_fcs_gen.sv
// CRC accumulator for one transmit frame plus the FCS byte selector.
// The register holds still whenever neither init nor advance is asserted,
// which is how the FCS value stays frozen while its bytes are drained.
module eth_fcs_gen
  import rx_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_i,
  input  logic                  adv_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            sel_i,
  output logic [DATA_WIDTH-1:0] fcs_byte_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_inv;

  // Seed, advance or hold the running CRC.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC32_INIT;
    end else if (adv_i) begin
      crc_d = crc32_next(data_i, crc_q);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_inv = ~crc_q;

  // Pick FCS byte sel_i (byte 0 = low-order bits) and bit-reverse it.
  always_comb begin
    fcs_byte_o = '0;
    unique case (sel_i)
      2'd0: fcs_byte_o = reflect8(crc_inv[7:0]);
      2'd1: fcs_byte_o = reflect8(crc_inv[15:8]);
      2'd2: fcs_byte_o = reflect8(crc_inv[23:16]);
      2'd3: fcs_byte_o = reflect8(crc_inv[31:24]);
      default: fcs_byte_o = '0;
    endcase
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Transmit frame sequencer: wraps an egress byte stream with preamble/SFD,
// pads short frames, appends FCS and enforces the inter-frame gap.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for in_valid (and for any aborted frame to drain)
//   PREAMBLE  | PREAMBLE_LEN x 0x55
//   SFD       | one 0xD5
//   DATA      | forwarding accepted bytes into tx_data and the CRC
//   PAD       | zero bytes until MIN_DATA_BYTES have been sent
//   FCS       | four frozen CRC bytes, frame_done on the last one
//   IFG       | IFG_BYTES idle byte times; may chain straight into PREAMBLE
module eth_tx_framer
  import rx_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  output logic                  tx_err,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam logic [BYTE_CNT_W-1:0] MIN_CNT = BYTE_CNT_W'(MIN_DATA_BYTES);
  localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_DATA_BYTES);
  localparam logic [3:0]            PRE_END = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0]            IFG_END = 4'(IFG_BYTES - 1);

  tx_state_e             state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_inc;
  logic [3:0]            cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_en_q, tx_en_d;
  logic                  tx_err_q, tx_err_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  crc_init;
  logic                  crc_adv;
  logic [DATA_WIDTH-1:0] crc_din;
  logic [DATA_WIDTH-1:0] fcs_byte;
  logic                  start;

  eth_fcs_gen u_fcs (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_i     (crc_init),
    .adv_i      (crc_adv),
    .data_i     (crc_din),
    .sel_i      (cnt_q[1:0]),
    .fcs_byte_o (fcs_byte)
  );

  // Draining an aborted frame also needs the input handshake open.
  assign in_ready     = (state_q == TX_DATA) || drain_q;
  assign start        = in_valid && !drain_q;
  assign byte_cnt_inc = byte_cnt_q + BYTE_CNT_W'(1);

  // Next-state, counters, CRC control and the byte selected for the wire.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    tx_data_d    = '0;
    tx_en_d      = 1'b0;
    tx_err_d     = 1'b0;
    frame_done_d = 1'b0;
    crc_init     = 1'b0;
    crc_adv      = 1'b0;
    crc_din      = '0;

    if (drain_q && in_valid && in_last) begin
      drain_d = 1'b0;
    end

    unique case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d    = TX_PREAMBLE;
          cnt_d      = '0;
          byte_cnt_d = '0;
          crc_init   = 1'b1;
        end
      end
      TX_PREAMBLE: begin
        tx_data_d = PREAMBLE_BYTE;
        tx_en_d   = 1'b1;
        if (cnt_q == PRE_END) begin
          state_d = TX_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      TX_SFD: begin
        tx_data_d = SFD_BYTE;
        tx_en_d   = 1'b1;
        state_d   = TX_DATA;
      end
      TX_DATA: begin
        tx_en_d = 1'b1;
        if (!in_valid || byte_cnt_q == MAX_CNT) begin
          // Underrun or oversize: one error byte, then discard to in_last.
          tx_err_d = 1'b1;
          state_d  = TX_IFG;
          cnt_d    = '0;
          drain_d  = !(in_valid && in_last);
        end else begin
          tx_data_d  = in_data;
          crc_adv    = 1'b1;
          crc_din    = in_data;
          byte_cnt_d = byte_cnt_inc;
          if (in_last) begin
            state_d = (byte_cnt_inc < MIN_CNT) ? TX_PAD : TX_FCS;
            cnt_d   = '0;
          end
        end
      end
      TX_PAD: begin
        tx_en_d    = 1'b1;
        crc_adv    = 1'b1;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc == MIN_CNT) begin
          state_d = TX_FCS;
          cnt_d   = '0;
        end
      end
      TX_FCS: begin
        tx_data_d = fcs_byte;
        tx_en_d   = 1'b1;
        if (cnt_q == 4'd3) begin
          frame_done_d = 1'b1;
          state_d      = TX_IFG;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      TX_IFG: begin
        if (cnt_q == IFG_END) begin
          cnt_d = '0;
          if (start) begin
            // Back-to-back frame: skip the IDLE cycle so the gap stays exact.
            state_d    = TX_PREAMBLE;
            byte_cnt_d = '0;
            crc_init   = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase

    tx_busy_d = (state_d != TX_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      byte_cnt_q   <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      tx_data_q    <= '0;
      tx_en_q      <= 1'b0;
      tx_err_q     <= 1'b0;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      tx_err_q     <= tx_err_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign tx_err     = tx_err_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule
